vgm_sequencer: RTL
==================

// Module: vgm_sequencer
// PURPOSE
//  Sequences one vector_generator (VGM) plus its downstream MAC array for one conv layer.
//  Holds the VGM in reset until a layer config arrives, then waits out the VGM setup cycles.
//  Runs NON_ZERO_WEIGHTS steps per input tile, drains the MAC pipeline, then hands the result downstream.
//  Sits between the activation tile buffer (upstream), the VGM/MAC datapath and the output writer.
// PARAMETERS
//  NON_ZERO_WEIGHTS  6  non-zero weights per sparse filter = VGM steps per tile (>=1)
//  SETUP_CYCLES      3  cycles after VGM reset release before first step (VGM setup + index calc + act load)
//  PIPE_LAT          2  MAC pipeline depth, cycles from last mac_en to result valid (>=0)
//  TILE_W            8  width of the tile counter / cfg_num_tiles
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous reset, active-high
//  cfg_valid      in   1       layer config offered
//  cfg_ready      out  1       config accepted when cfg_valid & cfg_ready
//  cfg_num_tiles  in   TILE_W  tiles in this layer (0 allowed)
//  act_valid      in   1       upstream tile available on VGM in_activations
//  act_ready      out  1       tile consumed when act_valid & act_ready
//  vgm_rst_n      out  1       active-low reset into VGM/MAC datapath
//  mac_clear      out  1       clear MAC accumulators (1-cycle pulse before a tile's steps)
//  mac_en         out  1       MAC accumulate enable, high on every step
//  mac_last       out  1       high on the final step of a tile
//  step           out  clog2(NON_ZERO_WEIGHTS)+1  current step index 0..NON_ZERO_WEIGHTS-1
//  res_valid      out  1       tile result valid to downstream
//  res_ready      in   1       downstream accepts when res_valid & res_ready
//  tile_idx       out  TILE_W  index of tile currently in flight
//  busy           out  1       high in every state except IDLE
//  done           out  1       1-cycle pulse when the layer's last result is accepted
// BEHAVIOUR
//  Reset (rst=1 at a rising edge): state=IDLE; vgm_rst_n=0; cfg_ready=1; all other outputs 0; counters 0.
//  States: IDLE, SETUP, WAIT_ACT, CLEAR, RUN, DRAIN, OUT, DONE. All outputs registered except cfg_ready/act_ready (state decode).
//  IDLE: cfg_ready=1; on cfg handshake latch num_tiles, tile_idx<=0;
//    num_tiles==0 -> DONE; else vgm_rst_n<=1, -> SETUP.
//  SETUP: count SETUP_CYCLES cycles, then -> WAIT_ACT. cfg_valid is ignored outside IDLE.
//  WAIT_ACT: act_ready=1; on handshake -> CLEAR. Stall indefinitely while act_valid=0.
//  CLEAR: mac_clear=1 for exactly 1 cycle -> RUN with step=0.
//  RUN: mac_en=1 for NON_ZERO_WEIGHTS consecutive cycles, step 0..NON_ZERO_WEIGHTS-1; mac_last=1 when step==max;
//    step wraps to 0 after last step -> DRAIN (or straight to OUT if PIPE_LAT==0). Never stalls mid-tile.
//  DRAIN: wait PIPE_LAT cycles, mac_en=0 -> OUT.
//  OUT: res_valid=1 held until res_ready (res_ready high on entry = accepted that cycle);
//    on accept: tile_idx==num_tiles-1 -> DONE, else tile_idx+1, -> WAIT_ACT.
//  DONE: done=1 for 1 cycle, vgm_rst_n<=0 -> IDLE.
//  Latency per tile (no stalls): 1 (act) + 1 (clear) + NON_ZERO_WEIGHTS + PIPE_LAT + 1 (out) cycles.
//  rst mid-operation: abandons the tile, returns to the reset state next cycle; no done pulse; accepted data is dropped.
//  tile_idx counter is TILE_W wide, no overflow possible (bounded by num_tiles-1).
//  mac_en, mac_clear, res_valid mutually exclusive.
// STRUCTURE
//  Shared package vgm_pkg: state encoding localparams (ST_IDLE..ST_DONE, 3 bits) and STEP_W = clog2(NON_ZERO_WEIGHTS)+1,
//    reused by vector_generator wrappers and the layer top.
//  One sub-module: vgm_cycle_counter (load/decrement/zero-flag counter), shared by SETUP, RUN and DRAIN waits.
//  FSM and handshake logic stay in vgm_sequencer.
// TESTING
//  1 cfg num_tiles=2, act_valid/res_ready always 1 -> 2 res_valid pulses, tile_idx 0,1, done 1 cycle after 2nd accept.
//  2 cfg num_tiles=0 -> cfg accepted, no mac_en/act_ready ever, done pulses 1 cycle later, vgm_rst_n stays 0.
//  3 hold act_valid=0 for 10 cycles in WAIT_ACT -> act_ready held, no mac_clear/mac_en until act_valid rises.
//  4 hold res_ready=0 for 5 cycles in OUT -> res_valid stays 1, tile_idx stable, next act_ready only after accept.
//  5 assert rst on RUN step 3 -> next cycle IDLE, vgm_rst_n=0, mac_en=0, cfg_ready=1, no done.
//  6 NON_ZERO_WEIGHTS=6: mac_en high exactly 6 consecutive cycles, step 0..5, mac_last only at step 5.

Source files
------------

// File: rtl/vgm_pkg.sv
// Shared definitions for the vector generator sequencing logic: state
// encoding and step-index sizing reused by VGM wrappers and the layer top.
package vgm_pkg;

    localparam int NZW_DEFAULT = 6;
    localparam int STEP_W      = $clog2(NZW_DEFAULT) + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WAIT_ACT = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_RUN      = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_OUT      = 3'd6,
        ST_DONE     = 3'd7
    } state_e;

    function automatic int step_w(input int nzw);
        return $clog2(nzw) + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vgm_cycle_counter.sv
// Down-counter with load and a zero flag; times the SETUP, RUN and DRAIN
// phases of the sequencer. Load takes priority over decrement.
module vgm_cycle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/vgm_sequencer.sv
// Per-layer sequencer for one vector generator and its MAC array: config,
// setup wait, per-tile clear/run/drain, and result hand-off downstream.
module vgm_sequencer
    import vgm_pkg::*;
#(
    parameter int NON_ZERO_WEIGHTS = 6,
    parameter int SETUP_CYCLES     = 3,
    parameter int PIPE_LAT         = 2,
    parameter int TILE_W           = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [TILE_W-1:0]                 cfg_num_tiles,
    input  logic                              act_valid,
    output logic                              act_ready,
    output logic                              vgm_rst_n,
    output logic                              mac_clear,
    output logic                              mac_en,
    output logic                              mac_last,
    output logic [$clog2(NON_ZERO_WEIGHTS):0] step,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [TILE_W-1:0]                 tile_idx,
    output logic                              busy,
    output logic                              done
);

    localparam int SW = step_w(NON_ZERO_WEIGHTS);
    localparam int CW = $clog2(max3(SETUP_CYCLES, NON_ZERO_WEIGHTS, PIPE_LAT) + 1);

    state_e            state_q, state_d;
    logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
    logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
    logic [SW-1:0]     step_q, step_d;
    logic              vgm_rst_n_q, vgm_rst_n_d;
    logic              mac_clear_q, mac_clear_d;
    logic              mac_en_q, mac_en_d;
    logic              mac_last_q, mac_last_d;
    logic              res_valid_q, res_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]     cnt_val;

    vgm_cycle_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        num_tiles_d = num_tiles_q;
        tile_idx_d  = tile_idx_q;
        step_d      = step_q;
        vgm_rst_n_d = vgm_rst_n_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_dec     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    num_tiles_d = cfg_num_tiles;
                    tile_idx_d  = '0;
                    if (cfg_num_tiles == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        vgm_rst_n_d = 1'b1;
                        if (SETUP_CYCLES == 0) begin
                            state_d = ST_WAIT_ACT;
                        end else begin
                            state_d  = ST_SETUP;
                            cnt_load = 1'b1;
                            cnt_val  = CW'(SETUP_CYCLES - 1);
                        end
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_zero)
                    state_d = ST_WAIT_ACT;
                else
                    cnt_dec = 1'b1;
            end
            ST_WAIT_ACT: begin
                if (act_valid)
                    state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d  = ST_RUN;
                step_d   = '0;
                cnt_load = 1'b1;
                cnt_val  = CW'(NON_ZERO_WEIGHTS - 1);
            end
            ST_RUN: begin
                // Counter holds the steps remaining; step_q is the index shown to the VGM.
                if (cnt_zero) begin
                    step_d = '0;
                    if (PIPE_LAT == 0) begin
                        state_d = ST_OUT;
                    end else begin
                        state_d  = ST_DRAIN;
                        cnt_load = 1'b1;
                        cnt_val  = CW'(PIPE_LAT - 1);
                    end
                end else begin
                    cnt_dec = 1'b1;
                    step_d  = step_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_zero)
                    state_d = ST_OUT;
                else
                    cnt_dec = 1'b1;
            end
            ST_OUT: begin
                if (res_ready) begin
                    if (tile_idx_q == num_tiles_q - TILE_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        tile_idx_d = tile_idx_q + 1'b1;
                        state_d    = ST_WAIT_ACT;
                    end
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                vgm_rst_n_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with state_q.
        mac_clear_d = (state_d == ST_CLEAR);
        mac_en_d    = (state_d == ST_RUN);
        mac_last_d  = (state_d == ST_RUN) && (step_d == SW'(NON_ZERO_WEIGHTS - 1));
        res_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_tiles_q <= '0;
            tile_idx_q  <= '0;
            step_q      <= '0;
            vgm_rst_n_q <= 1'b0;
            mac_clear_q <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_last_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_tiles_q <= num_tiles_d;
            tile_idx_q  <= tile_idx_d;
            step_q      <= step_d;
            vgm_rst_n_q <= vgm_rst_n_d;
            mac_clear_q <= mac_clear_d;
            mac_en_q    <= mac_en_d;
            mac_last_q  <= mac_last_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cfg_ready = (state_q == ST_IDLE);
    assign act_ready = (state_q == ST_WAIT_ACT);
    assign vgm_rst_n = vgm_rst_n_q;
    assign mac_clear = mac_clear_q;
    assign mac_en    = mac_en_q;
    assign mac_last  = mac_last_q;
    assign step      = step_q;
    assign res_valid = res_valid_q;
    assign tile_idx  = tile_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
